// File: rtl/sha_nonce_feeder.sv
// Nonce sweeper and digest checker for the sha256 core: issues one block per cycle, compares returned digests against target, queues hit nonces.
// Outputs registered (first block the cycle after start); hit FIFO drops on full and raises a sticky overflow.
module sha_nonce_feeder #(
    parameter int HIT_DEPTH = 4,
    parameter int OUT_W     = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         start,
    input  logic         stop,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic [95:0]  work_data,
    input  logic [255:0] target,
    output logic         write_en,
    output logic [255:0] block_out,
    input  logic [255:0] digest_in,
    input  logic         digest_valid,
    output logic         hit_valid,
    output logic [31:0]  hit_nonce,
    input  logic         hit_ready,
    output logic         busy,
    output logic         done,
    output logic         overflow
);

    localparam int AW = $clog2(HIT_DEPTH);
    localparam logic [127:0] PAD = 128'h80000000_00000000_00000000_00000000;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t state;
    state_t state_nxt;

    logic [31:0]      end_q;
    logic [31:0]      cur_nonce;
    logic [31:0]      res_nonce;
    logic [95:0]      work_q;
    logic [255:0]     target_q;
    logic [OUT_W-1:0] outstanding;

    logic [31:0]      fifo_mem [HIT_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      fifo_cnt;

    logic dig_take;
    logic hit;
    logic pop;
    logic fifo_full;
    logic push_ok;

    // Digests beyond what was issued are stray and must not advance res_nonce.
    assign dig_take  = digest_valid && (outstanding != '0) && (state != S_IDLE);
    assign hit       = dig_take && (digest_in <= target_q);
    assign pop       = (fifo_cnt != '0) && hit_ready;
    assign fifo_full = (fifo_cnt == (AW+1)'(HIT_DEPTH));
    assign push_ok   = hit && (!fifo_full || pop);

    assign hit_valid = (fifo_cnt != '0);
    assign hit_nonce = fifo_mem[rd_ptr];

    // cur_nonce is the nonce on block_out this cycle; the FSM decides whether another follows.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ISSUE;
            S_ISSUE: if (stop || (cur_nonce == end_q)) state_nxt = S_DRAIN;
            S_DRAIN: if (outstanding == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            write_en    <= 1'b0;
            block_out   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            end_q       <= '0;
            cur_nonce   <= '0;
            res_nonce   <= '0;
            work_q      <= '0;
            target_q    <= '0;
            outstanding <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
        end else begin
            busy <= (state_nxt != S_IDLE);
            done <= (state_nxt == S_DONE);

            case ({write_en, dig_take})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase

            if (dig_take) res_nonce <= res_nonce + 32'd1;

            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)      fifo_cnt <= fifo_cnt + (AW+1)'(1);
            else if (pop && !push_ok) fifo_cnt <= fifo_cnt - (AW+1)'(1);
            if (hit && !push_ok) overflow <= 1'b1;

            if (state == S_IDLE && start) begin
                end_q     <= nonce_end;
                work_q    <= work_data;
                target_q  <= target;
                cur_nonce <= nonce_start;
                res_nonce <= nonce_start;
                write_en  <= 1'b1;
                block_out <= {work_data, nonce_start, PAD};
                overflow  <= 1'b0;
            end else if (state == S_ISSUE) begin
                if (state_nxt == S_ISSUE) begin
                    cur_nonce <= cur_nonce + 32'd1;
                    write_en  <= 1'b1;
                    block_out <= {work_q, cur_nonce + 32'd1, PAD};
                end else begin
                    write_en  <= 1'b0;
                end
            end
        end
    end

    // Storage needs no reset: fifo_cnt alone defines which entries are live.
    always_ff @(posedge CLK) begin
        if (push_ok) fifo_mem[wr_ptr] <= res_nonce;
    end

endmodule
